product_accumulator: RTL

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

---
 rtl/product_accumulator.sv | 105 ++++++++++
 1 files changed

// File: rtl/product_accumulator.sv
// Product accumulator: sums a batch of 8-bit products into a saturating accumulator,
// then streams the result out as a low byte followed by a high byte.
module product_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       prod_in,
  input  logic             prod_valid,
  output logic             prod_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             sat
);

  typedef enum logic [1:0] {IDLE, ACC, OUT_LO, OUT_HI} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [ACC_W-1:0] r_acc;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_count;
  logic             r_sat;
  logic [ACC_W:0]   w_sum;
  logic [15:0]      w_acc16;
  logic             w_xfer;
  logic             w_last;

  // A latched length of 0 wraps to all ones here, which yields a full 2^LEN_W batch.
  assign w_last = (r_count == (r_len - LEN_W'(1)));
  assign w_xfer = (r_state == ACC) && prod_valid;
  assign w_sum  = {1'b0, r_acc} + (ACC_W + 1)'(prod_in);
  assign sat    = r_sat;

  always_comb begin
    w_acc16 = '0;
    w_acc16[ACC_W-1:0] = r_acc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    prod_ready = 1'b0;
    out_valid  = 1'b0;
    out_data   = 8'h00;
    busy       = 1'b1;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next = ACC;
      end
      ACC: begin
        prod_ready = 1'b1;
        if (w_xfer && w_last) w_next = OUT_LO;
      end
      OUT_LO: begin
        out_valid = 1'b1;
        out_data  = w_acc16[7:0];
        if (out_ready) w_next = OUT_HI;
      end
      OUT_HI: begin
        out_valid = 1'b1;
        out_data  = w_acc16[15:8];
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Once the carry-out fires the accumulator pins at all ones; adding more keeps it there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_len   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if ((r_state == IDLE) && start) begin
      r_len   <= len;
      r_acc   <= '0;
      r_count <= '0;
      r_sat   <= 1'b0;
    end else if (w_xfer) begin
      r_count <= r_count + LEN_W'(1);
      if (w_sum[ACC_W]) begin
        r_acc <= '1;
        r_sat <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end

endmodule
